frame_compositor: RTL and testbench
===================================

// Module: frame_compositor
// PURPOSE
//  Pixel-stream stage directly downstream of the dinosaur jump sprite generator and obstacle generator.
//  Merges the per-pixel dino/obstacle/ground bits into 12-bit VGA colour, detects dino/obstacle overlap,
//  runs the game-over FSM, and keeps a 4-digit BCD distance score.
//  Drives the VGA colour pins and feeds the score display.
// PARAMETERS
//  MIN_HIT      4        overlapping pixels per frame required to declare a collision (graze filter)
//  SCORE_DIV    6        RUN frames per score increment
//  FLASH_FRAMES 30       frames spent in FLASH before OVER
//  FLASH_PERIOD 5        frames per palette-invert phase during FLASH
//  BG_RGB       12'hFFF  background colour
//  GND_RGB      12'h777  ground colour
//  OBS_RGB      12'h555  obstacle colour
//  DINO_RGB     12'h333  dino colour
// PORTS
//  CLK         in   1   pixel clock, same clock as the sprite generators
//  RESET       in   1   reset, synchronous, active-high
//  fresh       in   1   frame strobe; falling edge marks the frame boundary
//  restart     in   1   jump button, level; its rising edge restarts the game from OVER
//  row_addr    in   9   current row, already aligned with the *_px inputs
//  col_addr    in   10  current column, already aligned with the *_px inputs
//  game_status in   1   1 = game started (from the jump stage)
//  dino_px     in   1   dino sprite pixel
//  obst_px     in   1   obstacle pixel
//  ground_px   in   1   ground line pixel
//  rgb         out  12  {R4,G4,B4} colour, registered
//  collision   out  1   one-CLK pulse when FLASH is entered
//  game_over   out  1   high in OVER
//  score       out  16  4-digit BCD {thousands,hundreds,tens,units}
// BEHAVIOUR
//  Reset: rgb=0, collision=0, game_over=0, score=16'h0000, state=IDLE, all counters 0, fresh_d=1, restart_d=1.
//  Edge detection:
//   - fresh_d and restart_d are registered every CLK.
//   - frame_tick = fresh_d & ~fresh.
//   - restart_rise = ~restart_d & restart.
//  Active area: row_addr<480 && col_addr<640. Outside it rgb=12'h000.
//  Colour: one register stage, so rgb is valid 1 CLK after its addr/px inputs.
//   - Priority: dino > obstacle > ground > background.
//   - In FLASH, rgb is bitwise-inverted while (flash_cnt/FLASH_PERIOD) is odd. Black outside the active area is never inverted.
//  Overlap: ov = dino_px & obst_px & active.
//   - hit_cnt (12b, saturating at 4095) increments on each ov cycle.
//   - hit = (hit_cnt + ov) >= MIN_HIT, so an ov in the same cycle as frame_tick counts toward the ending frame.
//   - hit_cnt clears on every frame_tick, after it has been evaluated.
//  FSM (all transitions take effect on the CLK edge where the condition is true):
//   - IDLE:  score, div_cnt and hit_cnt are held at 0. frame_tick & game_status -> RUN.
//   - RUN, frame_tick & hit: -> FLASH, collision=1 for that one cycle, flash_cnt=0, score frozen.
//   - RUN, frame_tick & !hit: div_cnt++. When div_cnt reaches SCORE_DIV-1, div_cnt=0 and score increments in BCD.
//   - Score saturates at 16'h9999. Carry ripples per digit (9 -> 0 with carry); no digit ever holds A-F.
//   - FLASH: flash_cnt++ on each frame_tick. At flash_cnt==FLASH_FRAMES-1 with frame_tick -> OVER.
//   - OVER: game_over=1 and the score is held. Non-inverted palette.
//   - OVER, restart_rise: -> IDLE, score=0. A restart_rise that is simultaneous with a frame_tick also takes OVER -> IDLE.
//   - restart is ignored in every state other than OVER.
//   - game_status falling to 0 in RUN or FLASH: -> IDLE on the next frame_tick. Score is held until IDLE is entered, then cleared.
//  RESET mid-frame or mid-FLASH returns every output to its reset value on the next edge; no partial frame is scored.
// TESTING
//  1 Colour priority: active pixel with dino_px=obst_px=ground_px=1 -> rgb=12'h333 one CLK later.
//    Same pixel with only ground_px=1 -> 12'h777. col_addr=700 -> 12'h000.
//  2 Graze filter: RUN, 3 ov cycles in one frame -> no collision and the score keeps counting.
//    4 ov cycles, the 4th on the frame_tick cycle -> collision pulse on that edge, state FLASH.
//  3 Score: RUN with no overlap for 6*10 frames -> score=16'h0010.
//    Preload 9999 via a long run (or force) -> stays 16'h9999, never 16'h999A.
//  4 Flash/over: after collision, rgb inverted (BG -> 12'h000) in frames 5-9.
//    game_over=1 after frame_tick 30. Score is unchanged throughout.
//  5 Restart: in OVER, restart 0->1 -> IDLE and score=0. restart held high in RUN -> no effect.
//  6 Reset: RESET asserted during FLASH -> next edge rgb=0, collision=0, game_over=0, score=0, state IDLE.

Source files
------------

// File: rtl/frame_compositor_if.sv
// rtl/frame_compositor_if.sv - pixel-in / colour-and-game-state-out bundle for frame_compositor
interface frame_compositor_if;
    logic        fresh;
    logic        restart;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        game_status;
    logic        dino_px;
    logic        obst_px;
    logic        ground_px;
    logic [11:0] rgb;
    logic        collision;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output fresh, restart, row_addr, col_addr, game_status, dino_px, obst_px, ground_px,
        input  rgb, collision, game_over, score
    );

    modport slave (
        input  fresh, restart, row_addr, col_addr, game_status, dino_px, obst_px, ground_px,
        output rgb, collision, game_over, score
    );
endinterface

// File: rtl/frame_compositor.sv
// rtl/frame_compositor.sv - merges sprite pixels into VGA colour, detects overlap, runs game-over FSM and BCD score
module frame_compositor #(
    parameter int          MIN_HIT      = 4,
    parameter int          SCORE_DIV    = 6,
    parameter int          FLASH_FRAMES = 30,
    parameter int          FLASH_PERIOD = 5,
    parameter logic [11:0] BG_RGB       = 12'hFFF,
    parameter logic [11:0] GND_RGB      = 12'h777,
    parameter logic [11:0] OBS_RGB      = 12'h555,
    parameter logic [11:0] DINO_RGB     = 12'h333
) (
    input  logic              CLK,
    input  logic              RESET,
    frame_compositor_if.slave bus
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int DW = $clog2(SCORE_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLASH, S_OVER} state_t;

    state_t         state_q, state_d;
    logic           fresh_q, restart_q;
    logic [11:0]    hit_cnt_q, hit_cnt_d;
    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
    logic [15:0]    score_q, score_d;
    logic [11:0]    rgb_q, rgb_d;
    logic           collision_q, collision_d;
    logic           game_over_q, game_over_d;

    logic        frame_tick, restart_rise, active, ov, hit, flash_odd;
    logic [12:0] hit_sum;
    logic [11:0] hit_cnt_sat, pix;

    // Saturating BCD increment; each digit wraps 9->0 and carries into the next.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign frame_tick   = fresh_q & ~bus.fresh;
    assign restart_rise = ~restart_q & bus.restart;
    assign active       = (bus.row_addr < 9'd480) && (bus.col_addr < 10'd640);
    assign ov           = bus.dino_px & bus.obst_px & active;
    // The overlap of the current pixel is included so a hit on the frame_tick cycle still counts.
    assign hit_sum      = {1'b0, hit_cnt_q} + {12'b0, ov};
    assign hit          = hit_sum >= 13'(MIN_HIT);
    assign hit_cnt_sat  = (hit_cnt_q == 12'hFFF) ? hit_cnt_q : hit_cnt_q + {11'b0, ov};
    assign flash_odd    = ((flash_cnt_q / FW'(FLASH_PERIOD)) & FW'(1)) != '0;

    always_comb begin
        pix = BG_RGB;
        if (bus.dino_px) begin
            pix = DINO_RGB;
        end else if (bus.obst_px) begin
            pix = OBS_RGB;
        end else if (bus.ground_px) begin
            pix = GND_RGB;
        end
        rgb_d = 12'h000;
        if (active) begin
            rgb_d = (state_q == S_FLASH && flash_odd) ? ~pix : pix;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        div_cnt_d   = div_cnt_q;
        flash_cnt_d = flash_cnt_q;
        collision_d = 1'b0;
        hit_cnt_d   = frame_tick ? 12'd0 : hit_cnt_sat;
        case (state_q)
            S_IDLE: begin
                score_d   = 16'h0000;
                div_cnt_d = '0;
                hit_cnt_d = 12'd0;
                if (frame_tick && bus.game_status) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_tick) begin
                    if (!bus.game_status) begin
                        state_d   = S_IDLE;
                        score_d   = 16'h0000;
                        div_cnt_d = '0;
                    end else if (hit) begin
                        state_d     = S_FLASH;
                        collision_d = 1'b1;
                        flash_cnt_d = '0;
                    end else if (div_cnt_q == DW'(SCORE_DIV - 1)) begin
                        div_cnt_d = '0;
                        score_d   = bcd_inc(score_q);
                    end else begin
                        div_cnt_d = div_cnt_q + DW'(1);
                    end
                end
            end
            S_FLASH: begin
                hit_cnt_d = 12'd0;
                if (frame_tick) begin
                    if (!bus.game_status) begin
                        state_d   = S_IDLE;
                        score_d   = 16'h0000;
                        div_cnt_d = '0;
                    end else if (flash_cnt_q == FW'(FLASH_FRAMES - 1)) begin
                        state_d = S_OVER;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FW'(1);
                    end
                end
            end
            S_OVER: begin
                hit_cnt_d = 12'd0;
                if (restart_rise) begin
                    state_d   = S_IDLE;
                    score_d   = 16'h0000;
                    div_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            fresh_q     <= 1'b1;
            restart_q   <= 1'b1;
            hit_cnt_q   <= 12'd0;
            div_cnt_q   <= '0;
            flash_cnt_q <= '0;
            score_q     <= 16'h0000;
            rgb_q       <= 12'h000;
            collision_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= bus.fresh;
            restart_q   <= bus.restart;
            hit_cnt_q   <= hit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            score_q     <= score_d;
            rgb_q       <= rgb_d;
            collision_q <= collision_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.collision = collision_q;
    assign bus.game_over = game_over_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_frame_compositor.sv
// tb/tb_frame_compositor.sv - directed self-checking bench for frame_compositor
module tb_frame_compositor;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    frame_compositor_if bus ();
    frame_compositor dut (.CLK(clk), .RESET(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic d, input logic o, input logic g);
        bus.dino_px   = d;
        bus.obst_px   = o;
        bus.ground_px = g;
    endtask

    // n_ov overlap cycles, one quiet cycle, then the frame_tick cycle (optionally overlapping)
    task automatic frame(input int n_ov, input logic ov_tick);
        for (int i = 0; i < n_ov; i++) begin
            set_px(1'b1, 1'b1, 1'b0);
            tick();
        end
        set_px(1'b0, 1'b0, 1'b0);
        tick();
        bus.fresh = 1'b0;
        set_px(ov_tick, ov_tick, 1'b0);
        tick();
        bus.fresh = 1'b1;
        set_px(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.fresh       = 1'b1;
        bus.restart     = 1'b0;
        bus.game_status = 1'b0;
        bus.row_addr    = 9'd0;
        bus.col_addr    = 10'd0;
        set_px(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_rgb", bus.rgb, 12'h000);
        check("rst_collision", bus.collision, 1'b0);
        check("rst_game_over", bus.game_over, 1'b0);
        check("rst_score", bus.score, 16'h0000);
        rst = 1'b0;

        // colour priority and active-area boundary
        tick();
        check("bg", bus.rgb, 12'hFFF);
        set_px(1'b1, 1'b1, 1'b1); tick();
        check("prio_dino", bus.rgb, 12'h333);
        set_px(1'b0, 1'b1, 1'b1); tick();
        check("prio_obst", bus.rgb, 12'h555);
        set_px(1'b0, 1'b0, 1'b1); tick();
        check("prio_ground", bus.rgb, 12'h777);
        bus.col_addr = 10'd700; tick();
        check("col_outside", bus.rgb, 12'h000);
        bus.col_addr = 10'd0; bus.row_addr = 9'd480; tick();
        check("row_outside", bus.rgb, 12'h000);
        bus.col_addr = 10'd639; bus.row_addr = 9'd479; set_px(1'b0, 1'b0, 1'b0); tick();
        check("last_active", bus.rgb, 12'hFFF);
        bus.col_addr = 10'd0; bus.row_addr = 9'd0;

        // run, graze filter, score
        bus.game_status = 1'b1;
        frame(0, 1'b0);
        check("enter_run", 32'(dut.state_q), 1);
        frame(3, 1'b0);
        check("graze_no_collision", bus.collision, 1'b0);
        check("graze_state", 32'(dut.state_q), 1);
        for (int i = 1; i <= 59; i++) begin
            frame(0, 1'b0);
            if (i == 5) check("score_6_frames", bus.score, 16'h0001);
        end
        check("score_60_frames", bus.score, 16'h0010);
        frame(3, 1'b1);
        check("collision_pulse", bus.collision, 1'b1);
        check("state_flash", 32'(dut.state_q), 2);
        tick();
        check("collision_one_cycle", bus.collision, 1'b0);

        // flash palette and transition to over
        for (int k = 1; k <= 30; k++) begin
            frame(0, 1'b0);
            if (k < 30) begin
                tick();
                check($sformatf("flash_rgb_%0d", k), bus.rgb, ((k / 5) % 2 == 1) ? 12'h000 : 12'hFFF);
            end
            if (k == 6) begin
                bus.col_addr = 10'd700; tick();
                check("flash_outside_black", bus.rgb, 12'h000);
                bus.col_addr = 10'd0;
            end
            if (k == 7) begin
                set_px(1'b1, 1'b0, 1'b0); tick();
                check("flash_dino_inv", bus.rgb, 12'hCCC);
                set_px(1'b0, 1'b0, 1'b0);
            end
            if (k == 29) check("not_over_yet", bus.game_over, 1'b0);
        end
        check("game_over", bus.game_over, 1'b1);
        tick();
        check("over_palette", bus.rgb, 12'hFFF);
        check("over_score", bus.score, 16'h0010);

        // restart
        bus.restart = 1'b1; tick();
        check("restart_idle", 32'(dut.state_q), 0);
        check("restart_score", bus.score, 16'h0000);
        check("restart_game_over", bus.game_over, 1'b0);
        frame(0, 1'b0);
        bus.restart = 1'b0; tick();
        bus.restart = 1'b1; tick();
        check("restart_in_run", 32'(dut.state_q), 1);

        // BCD carry and saturation
        force dut.score_q = 16'h0999;
        tick();
        release dut.score_q;
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        check("bcd_carry", bus.score, 16'h1000);
        force dut.score_q = 16'h9998;
        tick();
        release dut.score_q;
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        check("score_9999", bus.score, 16'h9999);
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        check("score_saturate", bus.score, 16'h9999);

        // reset mid-flash
        frame(3, 1'b1);
        check("collision2", bus.collision, 1'b1);
        for (int i = 0; i < 7; i++) frame(0, 1'b0);
        set_px(1'b1, 1'b0, 1'b0); tick();
        check("flash2_dino_inv", bus.rgb, 12'hCCC);
        check("flash2_score", bus.score, 16'h9999);
        rst = 1'b1; tick();
        check("rst2_rgb", bus.rgb, 12'h000);
        check("rst2_collision", bus.collision, 1'b0);
        check("rst2_game_over", bus.game_over, 1'b0);
        check("rst2_score", bus.score, 16'h0000);
        check("rst2_state", 32'(dut.state_q), 0);
        rst = 1'b0;
        set_px(1'b0, 1'b0, 1'b0);

        // game_status drop returns to idle on the next frame_tick
        tick();
        frame(0, 1'b0);
        for (int i = 0; i < 6; i++) frame(0, 1'b0);
        check("drop_pre_score", bus.score, 16'h0001);
        bus.game_status = 1'b0;
        tick();
        tick();
        check("drop_hold_state", 32'(dut.state_q), 1);
        check("drop_hold_score", bus.score, 16'h0001);
        frame(0, 1'b0);
        check("drop_idle", 32'(dut.state_q), 0);
        check("drop_score_clear", bus.score, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
